// File: rtl/muldiv_seq_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
// The master side issues requests and consumes results; the slave is the unit.
interface muldiv_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             div_zero;
   logic             busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, res_hi, res_lo, div_zero, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, res_hi, res_lo, div_zero, busy
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit, one radix-2 step per clock.
// Both operations share the {hi, lo} register pair and the operand register:
// multiply runs shift-add with the multiplier in lo, divide runs restoring
// division with the dividend shifting out of lo and the quotient shifting in.
module muldiv_seq #(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic             op_q;
   logic             dz_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [CW-1:0]    cnt_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             div_zero_q;
   logic [WIDTH-1:0] res_hi_q;
   logic [WIDTH-1:0] res_lo_q;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH+1:0] div_trial;
   logic             div_neg;
   logic [WIDTH-1:0] step_hi_d;
   logic [WIDTH-1:0] step_lo_d;

   // One datapath step: shift-add for multiply, trial subtract for divide.
   // The trial carries an extra top bit so the borrow is visible even when
   // the shifted remainder itself needs WIDTH+1 bits.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_trial = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, opnd_q};
      div_neg   = |div_trial[WIDTH+1:WIDTH];
      if (!op_q) begin
         step_hi_d = mul_sum[WIDTH:1];
         step_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (div_neg) begin
         step_hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
         step_lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
         step_hi_d = div_trial[WIDTH-1:0];
         step_lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
   end

   // Control FSM with registered handshake/result outputs.
   // A divide by zero still passes through RUN for one cycle, so its result
   // appears one edge after accept instead of WIDTH edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= 1'b0;
         dz_q        <= 1'b0;
         opnd_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         res_hi_q    <= '0;
         res_lo_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  op_q       <= bus.op;
                  dz_q       <= bus.op && (bus.b == '0);
                  cnt_q      <= '0;
                  hi_q       <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
                  if (bus.op) begin
                     lo_q   <= bus.a;
                     opnd_q <= bus.b;
                  end else begin
                     lo_q   <= bus.b;
                     opnd_q <= bus.a;
                  end
               end
            end
            RUN: begin
               if (dz_q) begin
                  res_lo_q    <= '1;
                  res_hi_q    <= lo_q;
                  div_zero_q  <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  hi_q  <= step_hi_d;
                  lo_q  <= step_lo_d;
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CW'(WIDTH-1)) begin
                     res_hi_q    <= step_hi_d;
                     res_lo_q    <= step_lo_d;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  div_zero_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.res_hi    = res_hi_q;
   assign bus.res_lo    = res_lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results are queued at request
// time and compared when the unit hands a result over.
module tb_muldiv_seq;
   localparam int WIDTH = 16;

   typedef struct {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      logic             dz;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   n_txn;
   exp_t sb[$];

   muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

   muldiv_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      exp_t        e;
      logic [31:0] p;
      if (!o) begin
         p    = 32'(x) * 32'(y);
         e.hi = p[31:16];
         e.lo = p[15:0];
         e.dz = 1'b0;
      end else if (y == 0) begin
         e.hi = x;
         e.lo = 16'hFFFF;
         e.dz = 1'b1;
      end else begin
         e.hi = x % y;
         e.lo = x / y;
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Result monitor: compare each handed-over result with the oldest entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            n_txn++;
            $display("txn %0d: hi=%h lo=%h dz=%b (exp %h %h %b)",
                     n_txn, bus.res_hi, bus.res_lo, bus.div_zero, e.hi, e.lo, e.dz);
            check("res_hi", 32'(bus.res_hi), 32'(e.hi));
            check("res_lo", 32'(bus.res_lo), 32'(e.lo));
            check("div_zero", 32'(bus.div_zero), 32'(e.dz));
         end
      end
   end

   // Present a request after a rising edge; it is accepted on the next edge,
   // after which the operands are scrambled to prove they were captured.
   task automatic issue(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.a        = x;
      bus.b        = y;
      sb.push_back(model(o, x, y));
      @(negedge clk);
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op       = 1'($urandom);
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
   endtask

   // Count edges from accept until out_valid; in_ready must stay low meanwhile.
   task automatic wait_result(input int exp_lat);
      int   lat;
      logic ready_seen;
      lat        = 0;
      ready_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.out_valid) break;
         if (bus.in_ready) ready_seen = 1'b1;
         @(posedge clk);
         lat++;
         if (lat > 40) begin
            check("timeout", 32'd1, 32'd0);
            break;
         end
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("in_ready_busy", 32'(ready_seen), 32'd0);
      check("busy_done", 32'(bus.busy), 32'd1);
   endtask

   task automatic do_op(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      issue(o, x, y);
      wait_result((o && y == 0) ? 1 : WIDTH);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t bp;
      logic ov_seen;
      n_checks = 0;
      n_fail   = 0;
      n_txn    = 0;
      bus.in_valid  = 1'b0;
      bus.op        = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_div_zero", 32'(bus.div_zero), 32'd0);
      check("rst_res", {bus.res_hi, bus.res_lo}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Main function and boundaries
      do_op(1'b0, 16'hFFFF, 16'hFFFF);
      do_op(1'b1, 16'd100, 16'd7);
      do_op(1'b1, 16'd5, 16'd9);
      do_op(1'b1, 16'h1234, 16'h0000);
      do_op(1'b0, 16'h0000, 16'hFFFF);
      do_op(1'b0, 16'h1234, 16'h0000);
      do_op(1'b1, 16'h1234, 16'h1234);
      do_op(1'b1, 16'hFFFF, 16'h0001);
      do_op(1'b1, 16'hFFFF, 16'hFFFF);

      // Backpressure: result held, new request ignored until handshake
      issue(1'b0, 16'h00FF, 16'h0101);
      bus.out_ready = 1'b0;
      wait_result(WIDTH);
      bp = model(1'b0, 16'h00FF, 16'h0101);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = 1'b1;
      bus.a        = 16'd100;
      bus.b        = 16'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_res", {bus.res_hi, bus.res_lo}, {bp.hi, bp.lo});
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      sb.push_back(model(1'b1, 16'd100, 16'd7));
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
      check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_result(WIDTH);

      // Operand hold-off
      do_op(1'b0, 16'h8000, 16'h0002);

      // Reset in the middle of a divide, at counter 8
      issue(1'b1, 16'hBEEF, 16'h0003);
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_res", {bus.res_hi, bus.res_lo}, 32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      ov_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) ov_seen = 1'b1;
      end
      check("post_rst_no_valid", 32'(ov_seen), 32'd0);
      do_op(1'b0, 16'd3, 16'd4);

      // Random mix
      for (int i = 0; i < 8; i++) begin
         logic             ro;
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         ro = 1'($urandom_range(0, 1));
         ra = 16'($urandom);
         rb = (i == 3) ? 16'h0000 : 16'($urandom_range(0, (i % 2 == 0) ? 255 : 65535));
         do_op(ro, ra, rb);
      end

      @(posedge clk); #1;
      @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end
endmodule
